pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
Multi-channel successor to the single-channel PWM generator. NUM_CH outputs share one period counter, driven by a runtime prescaler, in edge-aligned or center-aligned mode. Duty, period and mode are double-buffered: a load request stages new values, which become active only at a PWM cycle boundary, so outputs never glitch. Per-channel output polarity is selectable. The block sits in the timer/peripheral cluster and drives motor, LED and servo pins.

Parameters:
WIDTH, 8, counter/period/duty resolution in bits
NUM_CH, 4, number of PWM channels (1..16)
PRESCALE_W, 8, prescaler register width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
enable  in  1  run counter; 0 = idle, outputs at inactive level
load_req  in  1  one-clk pulse; captures period, duty, center_mode into staging
period  in  WIDTH  max counter value P
duty  in  NUM_CH*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH]
center_mode  in  1  0 = edge-aligned, 1 = center-aligned
polarity  in  NUM_CH  1 = invert channel output (live, not staged)
prescale  in  PRESCALE_W  tick every prescale+1 clks (live)
load_ack  out  1  one-clk pulse when staged values become active
cycle_start  out  1  one-clk pulse on the tick the counter restarts at 0
pwm_out  out  NUM_CH  PWM outputs

Behaviour:
- Reset: counter 0, direction up, prescaler 0, staging/active regs 0, pending 0, pwm_out 0, load_ack 0, cycle_start 0.
- Prescaler: while enable=1, tick asserts when presc_cnt==prescale, then presc_cnt wraps to 0; prescale=0 gives a tick every clk. A prescale change takes effect at the next wrap; if presc_cnt > new prescale, the counter wraps to 0 on the next clk.
- Edge mode: counter runs 0,1..P,0 (period P+1 ticks). raw_i = (cnt < duty_i).
- Center mode: counter runs 0,1..P,P-1..1,0 (period 2P ticks); direction flips at P and at 0. raw_i = (cnt < duty_i), so the high time is 2*duty_i-1 ticks for 0 < duty_i <= P.
- Limits: duty_i=0 gives always low. duty_i>P gives always high. P=0: counter holds at 0, cycle_start pulses on every tick, raw_i = (duty_i != 0).
- Output: pwm_out[i] = raw_i XOR polarity[i], registered. Latency is 1 clk from the counter value to pwm_out.
- enable=0: counter 0, direction up, presc_cnt 0, no ticks. pwm_out[i] = polarity[i] one clk after enable falls.
- enable rise: the first tick starts at cnt=0 and cycle_start pulses on it.
- Staging: load_req=1 writes staging and sets pending. A second load_req before the boundary overwrites staging; only one load_ack results.
- Boundary: the tick where the counter goes to 0 (edge: the wrap from P; center: reaching 0 on the way down). If pending at the boundary, active <= staging, pending clears, and load_ack pulses on the same clk as cycle_start. The new values govern the cycle that starts there.
- load_req on the same clk as a boundary: active takes the old staging (ack pulses), staging takes the new values, pending stays 1, and the new values apply at the next boundary.
- Pending while enable=0: active <= staging on the next clk, with load_ack.
- Mode change at a boundary: the counter restarts at 0, direction up.
- A period shrink cannot strand the counter, because values apply only at cnt=0.
- rst mid-cycle: all state returns to reset values on the next clk edge; staged data is discarded.

Decomposition:
- pwm_pkg: mode constants MODE_EDGE/MODE_CENTER, direction constants DIR_UP/DIR_DOWN, and a duty-slice helper function.
- Sub-module pwm_prescaler (PRESCALE_W): clk, rst, enable, prescale in; tick out.
- Top holds the counter, direction, staging/active registers and a generate loop of NUM_CH comparators.

Test Plan:
- Edge, prescale=0, P=9, duty0=3 -> pwm_out[0] high 3 clks of every 10; cycle_start every 10 clks.
- Center, P=4, duty1=2 -> counter sequence 0,1,2,3,4,3,2,1; pwm_out[1] high 3 ticks per 8; cycle_start every 8 ticks.
- Edge, P=7, prescale=2, duty=0 / 4 / 8 / 255 on ch0..3 -> ch0 always low; ch1 high 12 of 24 clks; ch2 and ch3 always high.
- Mid-cycle load_req (duty0 3 -> 6) at cnt=2 -> unchanged until the wrap; load_ack coincides with cycle_start; next cycle is high 6 ticks.
- load_req on a boundary clk while pending -> two acks on consecutive boundaries, applying the old then the new values.
- polarity=4'b0101 with enable dropped mid-cycle -> pwm_out = 4'b0101 one clk later. rst asserted mid-cycle -> all outputs 0 and counter 0 on the next clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Mode/direction encodings and per-channel duty extraction.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MAX_W  = 32;
  localparam int MAX_CH = 16;

  // Returns channel ch's w-bit field of a packed duty bus, zero-extended.
  function automatic logic [MAX_W-1:0] duty_slice(
    input logic [MAX_CH*MAX_W-1:0] bus,
    input int                      ch,
    input int                      w
  );
    logic [MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b < w) r[b] = bus[ch*w + b];
    return r;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_prescaler.sv
// Clock prescaler: one tick every prescale+1 clocks while enabled.
// A prescale change takes effect at the next wrap.
module pwm_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = enable && (cnt == prescale);

  // cnt >= prescale also recovers when prescale shrinks below cnt
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (!enable || cnt >= prescale)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shared counter, edge/center modes and
// double-buffered period/duty/mode applied at cycle boundaries.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_req,
  input  logic [WIDTH-1:0]        period,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  input  logic                    center_mode,
  input  logic [NUM_CH-1:0]       polarity,
  input  logic [PRESCALE_W-1:0]   prescale,
  output logic                    load_ack,
  output logic                    cycle_start,
  output logic [NUM_CH-1:0]       pwm_out
);

  logic                    tick;
  logic                    fresh;
  logic                    pending;
  logic                    dir;
  logic                    nxt_dir;
  logic                    boundary;
  logic [WIDTH-1:0]        cnt;
  logic [WIDTH-1:0]        nxt_cnt;
  logic [WIDTH-1:0]        period_stg;
  logic [WIDTH-1:0]        period_act;
  logic [NUM_CH*WIDTH-1:0] duty_stg;
  logic [NUM_CH*WIDTH-1:0] duty_act;
  logic                    mode_stg;
  logic                    mode_act;
  logic [NUM_CH-1:0]       raw;

  pwm_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    nxt_cnt = cnt + 1'b1;
    nxt_dir = dir;
    if (mode_act == MODE_EDGE) begin
      if (cnt >= period_act)
        nxt_cnt = '0;
    end else if (dir == DIR_UP) begin
      if (period_act == '0) begin
        nxt_cnt = '0;
      end else if (cnt >= period_act) begin
        nxt_cnt = cnt - 1'b1;
        nxt_dir = DIR_DOWN;
      end
    end else begin
      nxt_cnt = cnt - 1'b1;
    end
  end

  // First tick after enable rises is treated as a cycle start at cnt=0
  assign boundary = tick && (fresh || nxt_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      fresh       <= 1'b1;
      pending     <= 1'b0;
      period_stg  <= '0;
      duty_stg    <= '0;
      mode_stg    <= MODE_EDGE;
      period_act  <= '0;
      duty_act    <= '0;
      mode_act    <= MODE_EDGE;
      load_ack    <= 1'b0;
      cycle_start <= 1'b0;
      pwm_out     <= '0;
    end else begin
      load_ack    <= 1'b0;
      cycle_start <= 1'b0;
      if (load_req) begin
        period_stg <= period;
        duty_stg   <= duty;
        mode_stg   <= center_mode;
      end
      if (!enable) begin
        cnt   <= '0;
        dir   <= DIR_UP;
        fresh <= 1'b1;
      end else if (boundary) begin
        cnt         <= '0;
        dir         <= DIR_UP;
        fresh       <= 1'b0;
        cycle_start <= 1'b1;
      end else if (tick) begin
        cnt <= nxt_cnt;
        dir <= nxt_dir;
      end
      if (pending && (boundary || !enable)) begin
        period_act <= period_stg;
        duty_act   <= duty_stg;
        mode_act   <= mode_stg;
        load_ack   <= 1'b1;
        pending    <= load_req;
      end else if (load_req) begin
        pending <= 1'b1;
      end
      pwm_out <= enable ? (raw ^ polarity) : polarity;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MAX_W-1:0] d;
    assign d      = duty_slice((MAX_CH*MAX_W)'(duty_act), i, WIDTH);
    assign raw[i] = MAX_W'(cnt) < d;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed self-checking bench for pwm_multi_channel.
// All outputs sampled on the falling clock edge.
module tb_pwm_multi_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load_req;
  logic [7:0]  period;
  logic [31:0] duty;
  logic        center_mode;
  logic [3:0]  polarity;
  logic [7:0]  prescale;
  logic        load_ack;
  logic        cycle_start;
  logic [3:0]  pwm_out;

  int errors = 0;
  int checks = 0;
  int hi[4];
  int ncs;
  int nack;
  logic [7:0] cseq[8];

  pwm_multi_channel dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load_req    (load_req),
    .period      (period),
    .duty        (duty),
    .center_mode (center_mode),
    .polarity    (polarity),
    .prescale    (prescale),
    .load_ack    (load_ack),
    .cycle_start (cycle_start),
    .pwm_out     (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ncs  = 0;
    nack = 0;
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++)
        if (pwm_out[c]) hi[c]++;
      if (cycle_start) ncs++;
      if (load_ack) nack++;
      @(negedge clk);
      load_req = 1'b0;
    end
  endtask

  task automatic wait_cs(input string tag);
    @(negedge clk);
    load_req = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (cycle_start) break;
      @(negedge clk);
      load_req = 1'b0;
    end
    chk(tag, 32'(cycle_start), 1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load_req = 1'b0;
    period = 8'd9; duty = {8'd0, 8'd0, 8'd0, 8'd3};
    center_mode = 1'b0; polarity = 4'b0000; prescale = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ack", 32'(load_ack), 0);
    chk("rst_cs", 32'(cycle_start), 0);
    chk("rst_cnt", 32'(dut.cnt), 0);

    // Edge, P=9, duty0=3, loaded while idle
    rst = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    chk("idle_load_ack", 32'(load_ack), 1);
    enable = 1'b1;
    @(negedge clk);
    chk("enable_first_cs", 32'(cycle_start), 1);
    wait_cs("edge_cs");
    clear();
    measure(20);
    chk("edge_hi0", hi[0], 6);
    chk("edge_hi1", hi[1], 0);
    chk("edge_ncs", ncs, 2);

    // Center, P=4, duty1=2
    period = 8'd4; center_mode = 1'b1;
    duty = {8'd0, 8'd0, 8'd2, 8'd3};
    load_req = 1'b1;
    wait_cs("ctr_cs");
    chk("ctr_ack", 32'(load_ack), 1);
    cseq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ctr_cnt%0d", k), 32'(dut.cnt), 32'(cseq[k]));
      @(negedge clk);
    end
    clear();
    measure(16);
    chk("ctr_hi1", hi[1], 6);
    chk("ctr_hi0", hi[0], 10);
    chk("ctr_ncs", ncs, 2);

    // Edge, P=7, prescale=2, duties 0/4/8/255
    prescale = 8'd2; period = 8'd7; center_mode = 1'b0;
    duty = {8'd255, 8'd8, 8'd4, 8'd0};
    load_req = 1'b1;
    wait_cs("lim_cs");
    chk("lim_ack", 32'(load_ack), 1);
    wait_cs("lim_cs2");
    clear();
    measure(48);
    chk("lim_hi0", hi[0], 0);
    chk("lim_hi1", hi[1], 24);
    chk("lim_hi2", hi[2], 48);
    chk("lim_hi3", hi[3], 48);
    chk("lim_ncs", ncs, 2);

    // Mid-cycle duty0 3 -> 6 at cnt=2
    duty = {8'd255, 8'd8, 8'd4, 8'd3};
    load_req = 1'b1;
    wait_cs("mid_cs");
    chk("mid_ack0", 32'(load_ack), 1);
    clear();
    measure(6);
    chk("mid_cnt2", 32'(dut.cnt), 2);
    duty = {8'd255, 8'd8, 8'd4, 8'd6};
    load_req = 1'b1;
    measure(18);
    chk("mid_old_hi0", hi[0], 9);
    chk("mid_nack", nack, 1);
    chk("mid_wrap_cs", 32'(cycle_start), 1);
    chk("mid_wrap_ack", 32'(load_ack), 1);
    clear();
    measure(24);
    chk("mid_new_hi0", hi[0], 18);

    // Load on the boundary clk while pending
    clear();
    measure(10);
    duty = {8'd255, 8'd8, 8'd4, 8'd2};
    load_req = 1'b1;
    measure(13);
    duty = {8'd255, 8'd8, 8'd4, 8'd5};
    load_req = 1'b1;
    measure(1);
    chk("bnd_cs1", 32'(cycle_start), 1);
    chk("bnd_ack1", 32'(load_ack), 1);
    clear();
    measure(24);
    chk("bnd_hiA", hi[0], 6);
    chk("bnd_cs2", 32'(cycle_start), 1);
    chk("bnd_ack2", 32'(load_ack), 1);
    clear();
    measure(24);
    chk("bnd_hiB", hi[0], 15);
    chk("bnd_nack", nack, 1);

    // Polarity and enable drop mid-cycle
    measure(5);
    polarity = 4'b0101;
    measure(1);
    chk("pol_live", 32'(pwm_out), 32'(4'b1010));
    enable = 1'b0;
    @(negedge clk);
    chk("dis_pwm", 32'(pwm_out), 32'(4'b0101));
    chk("dis_cnt", 32'(dut.cnt), 0);

    // Reset mid-cycle discards a pending load
    enable = 1'b1;
    measure(7);
    duty = 32'd0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_pwm", 32'(pwm_out), 0);
    chk("mrst_cnt", 32'(dut.cnt), 0);
    chk("mrst_cs", 32'(cycle_start), 0);
    chk("mrst_ack", 32'(load_ack), 0);
    rst = 1'b0;
    enable = 1'b0;
    clear();
    measure(4);
    chk("mrst_no_ack", nack, 0);
    chk("mrst_idle_pwm", 32'(pwm_out), 32'(4'b0101));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
